// File: rtl/alu_imm_iq.sv
// ALU reg-imm issue queue.
// Compressing, age-ordered queue: entry 0 holds the oldest op. Operand-A
// readiness is tracked by snooping the per-bank writeback bus, and the
// oldest ready entry is offered to the ALU reg-imm pipeline each cycle.

package core_types;
  localparam int PR_BITS        = 7;
  localparam int PRF_BANK_COUNT = 4;
  localparam int PR_bank_bits   = 2;
  localparam int upper_PR_bits  = PR_BITS - PR_bank_bits;
  localparam int ROB_BITS       = 7;

  typedef logic [PR_BITS-1:0]       PR_t;
  typedef logic [upper_PR_bits-1:0] upper_PR_t;
  typedef logic [ROB_BITS-1:0]      ROB_index_t;
endpackage

module alu_imm_iq #(
  parameter int ALU_IMM_IQ_ENTRIES = 8
) (
  input  logic                                                     CLK,
  input  logic                                                     nRST,
  input  logic                                                     iq_enq_valid,
  input  logic [3:0]                                               iq_enq_op,
  input  logic [11:0]                                              iq_enq_imm12,
  input  core_types::PR_t                                          iq_enq_A_PR,
  input  logic                                                     iq_enq_A_ready,
  input  logic                                                     iq_enq_A_is_zero,
  input  core_types::PR_t                                          iq_enq_dest_PR,
  input  core_types::ROB_index_t                                   iq_enq_ROB_index,
  output logic                                                     iq_enq_ready,
  input  logic [core_types::PRF_BANK_COUNT-1:0]                    WB_bus_valid_by_bank,
  input  core_types::upper_PR_t [core_types::PRF_BANK_COUNT-1:0]   WB_bus_upper_PR_by_bank,
  input  logic                                                     issue_ready,
  output logic                                                     issue_valid,
  output logic [3:0]                                               issue_op,
  output logic [11:0]                                              issue_imm12,
  output logic                                                     issue_A_forward,
  output logic                                                     issue_A_is_zero,
  output core_types::PR_t                                          issue_A_PR,
  output core_types::PR_t                                          issue_dest_PR,
  output core_types::ROB_index_t                                   issue_ROB_index
);

  localparam int N     = ALU_IMM_IQ_ENTRIES;
  localparam int IDX_W = $clog2(N);
  localparam int BB    = core_types::PR_bank_bits;
  localparam int PRB   = core_types::PR_BITS;

  typedef struct packed {
    logic                   valid;
    logic [3:0]             op;
    logic [11:0]            imm12;
    core_types::PR_t        a_pr;
    logic                   a_ready;
    logic                   a_zero;
    core_types::PR_t        dest_pr;
    core_types::ROB_index_t rob_index;
  } entry_t;

  entry_t           q_r   [N];
  entry_t           shf_s [N];
  entry_t           nxt_s [N];
  entry_t           enq_entry_s;
  logic [N-1:0]     wb_hit_s;
  logic [N-1:0]     ready_s;
  logic [IDX_W-1:0] sel_s;
  logic             any_ready_s;
  logic             issue_fire_s;
  logic             enq_fire_s;
  logic             placed_s;

  // Wakeup: compare each entry's A PR against the writeback slot of its bank.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wb_hit_s[i] = WB_bus_valid_by_bank[q_r[i].a_pr[BB-1:0]]
                  & (q_r[i].a_pr[PRB-1:BB] == WB_bus_upper_PR_by_bank[q_r[i].a_pr[BB-1:0]]);
      ready_s[i]  = q_r[i].valid & (q_r[i].a_ready | q_r[i].a_zero | wb_hit_s[i]);
    end
  end

  // Oldest-first select: scan from the top so the lowest ready index wins.
  always_comb begin
    sel_s       = '0;
    any_ready_s = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready_s[i]) begin
        sel_s       = IDX_W'(i);
        any_ready_s = 1'b1;
      end else begin
        sel_s       = sel_s;
        any_ready_s = any_ready_s;
      end
    end
  end

  assign issue_fire_s = any_ready_s & issue_ready;
  // Full check uses state only, so a same-cycle issue never frees a slot early.
  assign enq_fire_s   = iq_enq_valid & ~q_r[N-1].valid;

  // Compress over the issued slot; every surviving entry keeps any wakeup seen now.
  always_comb begin
    for (int i = 0; i < N - 1; i++) begin
      if (issue_fire_s && (IDX_W'(i) >= sel_s)) begin
        shf_s[i]         = q_r[i+1];
        shf_s[i].a_ready = q_r[i+1].a_ready | (wb_hit_s[i+1] & q_r[i+1].valid);
      end else begin
        shf_s[i]         = q_r[i];
        shf_s[i].a_ready = q_r[i].a_ready | (wb_hit_s[i] & q_r[i].valid);
      end
    end
    if (issue_fire_s) begin
      shf_s[N-1] = '0;
    end else begin
      shf_s[N-1]         = q_r[N-1];
      shf_s[N-1].a_ready = q_r[N-1].a_ready | (wb_hit_s[N-1] & q_r[N-1].valid);
    end
  end

  // Build the incoming entry; its readiness already includes any same-cycle WB hit.
  always_comb begin
    enq_entry_s           = '0;
    enq_entry_s.valid     = 1'b1;
    enq_entry_s.op        = iq_enq_op;
    enq_entry_s.imm12     = iq_enq_imm12;
    enq_entry_s.a_pr      = iq_enq_A_PR;
    enq_entry_s.a_ready   = iq_enq_A_ready;
    enq_entry_s.a_zero    = iq_enq_A_is_zero;
    enq_entry_s.dest_pr   = iq_enq_dest_PR;
    enq_entry_s.rob_index = iq_enq_ROB_index;
  end

  // Place an accepted enqueue in the lowest slot left empty after compression.
  always_comb begin
    nxt_s    = shf_s;
    placed_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (enq_fire_s && !placed_s && !shf_s[i].valid) begin
        nxt_s[i] = enq_entry_s;
        placed_s = 1'b1;
      end else begin
        nxt_s[i] = shf_s[i];
        placed_s = placed_s;
      end
    end
  end

  // Queue state register; reset flushes every entry immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < N; i++) begin
        q_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        q_r[i] <= nxt_s[i];
      end
    end
  end

  assign iq_enq_ready    = ~q_r[N-1].valid;
  assign issue_valid     = issue_fire_s;
  assign issue_op        = q_r[sel_s].op;
  assign issue_imm12     = q_r[sel_s].imm12;
  assign issue_A_PR      = q_r[sel_s].a_pr;
  assign issue_A_is_zero = q_r[sel_s].a_zero;
  assign issue_dest_PR   = q_r[sel_s].dest_pr;
  assign issue_ROB_index = q_r[sel_s].rob_index;
  // Bypass only when the operand is being produced right now and was not already in the PRF.
  assign issue_A_forward = wb_hit_s[sel_s] & ~q_r[sel_s].a_ready & ~q_r[sel_s].a_zero;

endmodule

// File: tb/tb_alu_imm_iq.sv
// Self-checking bench for alu_imm_iq: expected issues are queued in the
// order the ops must leave the queue and compared as the DUT issues them.

module tb_alu_imm_iq;
  import core_types::*;

  logic                                 CLK = 1'b0;
  logic                                 nRST;
  logic                                 iq_enq_valid;
  logic [3:0]                           iq_enq_op;
  logic [11:0]                          iq_enq_imm12;
  PR_t                                  iq_enq_A_PR;
  logic                                 iq_enq_A_ready;
  logic                                 iq_enq_A_is_zero;
  PR_t                                  iq_enq_dest_PR;
  ROB_index_t                           iq_enq_ROB_index;
  logic                                 iq_enq_ready;
  logic [PRF_BANK_COUNT-1:0]            WB_bus_valid_by_bank;
  upper_PR_t [PRF_BANK_COUNT-1:0]       WB_bus_upper_PR_by_bank;
  logic                                 issue_ready;
  logic                                 issue_valid;
  logic [3:0]                           issue_op;
  logic [11:0]                          issue_imm12;
  logic                                 issue_A_forward;
  logic                                 issue_A_is_zero;
  PR_t                                  issue_A_PR;
  PR_t                                  issue_dest_PR;
  ROB_index_t                           issue_ROB_index;

  alu_imm_iq #(.ALU_IMM_IQ_ENTRIES(8)) dut (
    .CLK                     (CLK),
    .nRST                    (nRST),
    .iq_enq_valid            (iq_enq_valid),
    .iq_enq_op               (iq_enq_op),
    .iq_enq_imm12            (iq_enq_imm12),
    .iq_enq_A_PR             (iq_enq_A_PR),
    .iq_enq_A_ready          (iq_enq_A_ready),
    .iq_enq_A_is_zero        (iq_enq_A_is_zero),
    .iq_enq_dest_PR          (iq_enq_dest_PR),
    .iq_enq_ROB_index        (iq_enq_ROB_index),
    .iq_enq_ready            (iq_enq_ready),
    .WB_bus_valid_by_bank    (WB_bus_valid_by_bank),
    .WB_bus_upper_PR_by_bank (WB_bus_upper_PR_by_bank),
    .issue_ready             (issue_ready),
    .issue_valid             (issue_valid),
    .issue_op                (issue_op),
    .issue_imm12             (issue_imm12),
    .issue_A_forward         (issue_A_forward),
    .issue_A_is_zero         (issue_A_is_zero),
    .issue_A_PR              (issue_A_PR),
    .issue_dest_PR           (issue_dest_PR),
    .issue_ROB_index         (issue_ROB_index)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    ROB_index_t rob;
    logic       fwd;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [3:0] t_op   [128];
  logic [11:0] t_imm [128];
  PR_t        t_pr   [128];
  logic       t_zero [128];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic PR_t dest_of(input ROB_index_t r);
    return PR_t'(r) ^ 7'h55;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic enq(input ROB_index_t rob, input logic [3:0] op, input logic [11:0] imm,
                     input PR_t pr, input logic rdy, input logic zero);
    t_op[rob]        = op;
    t_imm[rob]       = imm;
    t_pr[rob]        = pr;
    t_zero[rob]      = zero;
    iq_enq_valid     = 1'b1;
    iq_enq_op        = op;
    iq_enq_imm12     = imm;
    iq_enq_A_PR      = pr;
    iq_enq_A_ready   = rdy;
    iq_enq_A_is_zero = zero;
    iq_enq_dest_PR   = dest_of(rob);
    iq_enq_ROB_index = rob;
    tick();
    iq_enq_valid     = 1'b0;
  endtask

  task automatic expect_issue(input ROB_index_t rob, input logic fwd);
    exp_t e;
    e.rob = rob;
    e.fwd = fwd;
    exp_q.push_back(e);
  endtask

  // One-cycle writeback of pr; checks whether an issue is offered in that cycle.
  task automatic wake(input PR_t pr, input logic exp_v);
    WB_bus_valid_by_bank                              = '0;
    WB_bus_valid_by_bank[pr[PR_bank_bits-1:0]]        = 1'b1;
    WB_bus_upper_PR_by_bank[pr[PR_bank_bits-1:0]]     = pr[PR_BITS-1:PR_bank_bits];
    @(negedge CLK);
    check("wake_issue_valid", 32'(issue_valid), 32'(exp_v));
    tick();
    WB_bus_valid_by_bank = '0;
  endtask

  // Scoreboard: every issue the DUT offers must match the next expected op.
  always @(negedge CLK) begin
    if (nRST === 1'b1 && issue_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue_rob", 32'(issue_ROB_index), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("iss_rob",   32'(issue_ROB_index), 32'(mon_e.rob));
        check("iss_op",    32'(issue_op),        32'(t_op[mon_e.rob]));
        check("iss_imm",   32'(issue_imm12),     32'(t_imm[mon_e.rob]));
        check("iss_apr",   32'(issue_A_PR),      32'(t_pr[mon_e.rob]));
        check("iss_dest",  32'(issue_dest_PR),   32'(dest_of(mon_e.rob)));
        check("iss_zero",  32'(issue_A_is_zero), 32'(t_zero[mon_e.rob]));
        check("iss_fwd",   32'(issue_A_forward), 32'(mon_e.fwd));
      end
    end
  end

  initial begin
    static PR_t        drain_pr  [7] = '{7'd47, 7'd44, 7'd40, 7'd41, 7'd42, 7'd45, 7'd46};
    static ROB_index_t drain_rob [7] = '{7'd17, 7'd14, 7'd10, 7'd11, 7'd12, 7'd15, 7'd16};

    nRST                    = 1'b0;
    iq_enq_valid            = 1'b0;
    iq_enq_op               = 4'h0;
    iq_enq_imm12            = 12'h000;
    iq_enq_A_PR             = '0;
    iq_enq_A_ready          = 1'b0;
    iq_enq_A_is_zero        = 1'b0;
    iq_enq_dest_PR          = '0;
    iq_enq_ROB_index        = '0;
    WB_bus_valid_by_bank    = '0;
    WB_bus_upper_PR_by_bank = '0;
    issue_ready             = 1'b1;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_issue_valid", 32'(issue_valid),     32'd0);
    check("rst_enq_ready",   32'(iq_enq_ready),    32'd1);
    check("rst_op",          32'(issue_op),        32'd0);
    check("rst_imm",         32'(issue_imm12),     32'd0);
    check("rst_rob",         32'(issue_ROB_index), 32'd0);
    check("rst_apr",         32'(issue_A_PR),      32'd0);
    check("rst_dest",        32'(issue_dest_PR),   32'd0);
    check("rst_fwd",         32'(issue_A_forward), 32'd0);
    check("rst_zero",        32'(issue_A_is_zero), 32'd0);
    tick();
    nRST = 1'b1;
    tick();

    // Single ready op issues the cycle after enqueue
    expect_issue(7'd5, 1'b0);
    enq(7'd5, 4'h3, 12'h7FF, 7'd20, 1'b1, 1'b0);
    @(negedge CLK);
    check("t1_valid", 32'(issue_valid),     32'd1);
    check("t1_op",    32'(issue_op),        32'd3);
    check("t1_imm",   32'(issue_imm12),     32'h7FF);
    check("t1_rob",   32'(issue_ROB_index), 32'd5);
    check("t1_fwd",   32'(issue_A_forward), 32'd0);
    @(negedge CLK);
    check("t1_drained", 32'(issue_valid), 32'd0);
    tick();

    // Younger ready op overtakes; older op issues on its wakeup with forward
    expect_issue(7'd2, 1'b0);
    expect_issue(7'd1, 1'b1);
    enq(7'd1, 4'hA, 12'h123, 7'd12, 1'b0, 1'b0);
    enq(7'd2, 4'h5, 12'h800, 7'd30, 1'b1, 1'b0);
    @(negedge CLK);
    check("t2_b_first", 32'(issue_ROB_index), 32'd2);
    @(negedge CLK);
    check("t2_a_waits", 32'(issue_valid), 32'd0);
    tick();
    wake(7'd12, 1'b1);

    // Fill, refuse a ninth op, wake a middle entry, then drain out of order
    for (int i = 0; i < 8; i++) begin
      enq(ROB_index_t'(10 + i), 4'(i), 12'(12'h200 + i), PR_t'(40 + i), 1'b0, 1'b0);
    end
    @(negedge CLK);
    check("t3_full_ready", 32'(iq_enq_ready), 32'd0);
    check("t3_no_issue",   32'(issue_valid),  32'd0);
    tick();
    iq_enq_valid     = 1'b1;
    iq_enq_op        = 4'hF;
    iq_enq_imm12     = 12'hFFF;
    iq_enq_A_PR      = 7'd99;
    iq_enq_A_ready   = 1'b1;
    iq_enq_A_is_zero = 1'b0;
    iq_enq_dest_PR   = 7'd1;
    iq_enq_ROB_index = 7'd99;
    tick();
    iq_enq_valid = 1'b0;
    expect_issue(7'd13, 1'b1);
    wake(7'd43, 1'b1);
    @(negedge CLK);
    check("t3_ready_after_issue", 32'(iq_enq_ready), 32'd1);
    tick();
    for (int i = 0; i < 7; i++) begin
      expect_issue(drain_rob[i], 1'b1);
      wake(drain_pr[i], 1'b1);
    end

    // Pipeline stalled: wakeup is latched, later issue reads the PRF
    issue_ready = 1'b0;
    enq(7'd20, 4'h7, 12'h321, 7'd50, 1'b0, 1'b0);
    enq(7'd21, 4'h8, 12'h654, 7'd51, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        wake(7'd50, 1'b0);
      end else begin
        @(negedge CLK);
        check("t4_hold", 32'(issue_valid), 32'd0);
        tick();
      end
    end
    expect_issue(7'd20, 1'b0);
    issue_ready = 1'b1;
    @(negedge CLK);
    check("t4_valid", 32'(issue_valid),     32'd1);
    check("t4_fwd",   32'(issue_A_forward), 32'd0);
    tick();
    expect_issue(7'd21, 1'b1);
    wake(7'd51, 1'b1);

    // Seven valid: issue and enqueue together, new op lands behind the rest
    issue_ready = 1'b0;
    enq(7'd30, 4'h1, 12'h030, 7'd55, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      enq(ROB_index_t'(31 + k), 4'(k + 2), 12'(12'h300 + k), PR_t'(60 + k), 1'b0, 1'b0);
    end
    expect_issue(7'd30, 1'b0);
    issue_ready = 1'b1;
    enq(7'd9, 4'h9, 12'h009, 7'd70, 1'b0, 1'b0);
    issue_ready = 1'b0;
    @(negedge CLK);
    check("t5_seven_valid", 32'(iq_enq_ready), 32'd1);
    tick();
    enq(7'd37, 4'hE, 12'h037, 7'd71, 1'b1, 1'b0);
    @(negedge CLK);
    check("t5_eight_valid", 32'(iq_enq_ready), 32'd0);
    tick();
    for (int k = 0; k < 6; k++) begin
      wake(PR_t'(60 + k), 1'b0);
    end
    wake(7'd70, 1'b0);
    for (int k = 0; k < 6; k++) begin
      expect_issue(ROB_index_t'(31 + k), 1'b0);
    end
    expect_issue(7'd9, 1'b0);
    expect_issue(7'd37, 1'b0);
    issue_ready = 1'b1;
    repeat (8) tick();
    @(negedge CLK);
    check("t5_empty", 32'(issue_valid), 32'd0);
    tick();

    // x0 source issues without any writeback
    expect_issue(7'd40, 1'b0);
    enq(7'd40, 4'hC, 12'hABC, 7'd0, 1'b0, 1'b1);
    @(negedge CLK);
    check("t6_valid", 32'(issue_valid),     32'd1);
    check("t6_zero",  32'(issue_A_is_zero), 32'd1);
    check("t6_fwd",   32'(issue_A_forward), 32'd0);
    tick();

    // Reset mid-operation flushes pending entries
    enq(7'd50, 4'h2, 12'h050, 7'd80, 1'b0, 1'b0);
    enq(7'd51, 4'h3, 12'h051, 7'd81, 1'b0, 1'b0);
    @(negedge CLK);
    check("t7_pending", 32'(issue_valid), 32'd0);
    nRST = 1'b0;
    #1;
    check("t7_rst_enq_ready", 32'(iq_enq_ready), 32'd1);
    check("t7_rst_valid",     32'(issue_valid),  32'd0);
    tick();
    nRST = 1'b1;
    tick();
    wake(7'd80, 1'b0);
    wake(7'd81, 1'b0);

    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
